// File: rtl/uart_bus_bridge.sv
// Memory-mapped bridge between the core data bus and the minimal UART FIFOs.
// Decodes DATA/STATUS/CONTROL/reserved, serialises byte-enabled writes into TX pushes.
module uart_bus_bridge #(
    parameter logic [8:0] THRESH_RESET = 9'd1,
    parameter int         COUNT_WIDTH  = 9
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [1:0]             Address,
    input  logic [31:0]            DataIn,
    input  logic [3:0]             Write,
    input  logic                   Read,
    output logic [31:0]            DataOut,
    output logic                   Ack,
    output logic                   irq,
    output logic                   uart_write,
    output logic [7:0]             uart_data_in,
    output logic                   uart_read,
    input  logic [7:0]             uart_data_out,
    input  logic                   uart_data_ready,
    input  logic [COUNT_WIDTH-1:0] uart_rx_count
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PUSH      = 2'd1,
        ACK       = 2'd2,
        WAIT_DROP = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] data_q, data_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] dout_q, dout_d;
    logic        ack_q, ack_d;
    logic        irq_q, irq_d;
    logic        wr_q, wr_d;
    logic [7:0]  wbyte_q, wbyte_d;
    logic        rd_q, rd_d;
    logic        irq_en_q, irq_en_d;
    logic [8:0]  thresh_q, thresh_d;
    logic [1:0]  lane_s;
    logic [8:0]  rx_cnt_s;

    assign rx_cnt_s = uart_rx_count[8:0];

    // Highest enabled byte lane; bytes leave MSB first.
    function automatic logic [1:0] top_lane(input logic [3:0] be);
        logic [1:0] idx;
        if (be[3]) begin
            idx = 2'd3;
        end else if (be[2]) begin
            idx = 2'd2;
        end else if (be[1]) begin
            idx = 2'd1;
        end else begin
            idx = 2'd0;
        end
        return idx;
    endfunction

    function automatic logic [7:0] lane_byte(input logic [31:0] w, input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd3:    b = w[31:24];
            2'd2:    b = w[23:16];
            2'd1:    b = w[15:8];
            default: b = w[7:0];
        endcase
        return b;
    endfunction

    function automatic logic [3:0] clear_lane(input logic [3:0] be, input logic [1:0] idx);
        return be & ~(4'b0001 << idx);
    endfunction

    // Next-state, register-update and bus-response decode.
    always_comb begin
        state_d  = state_q;
        data_d   = data_q;
        be_d     = be_q;
        dout_d   = dout_q;
        wr_d     = 1'b0;
        wbyte_d  = wbyte_q;
        rd_d     = 1'b0;
        irq_en_d = irq_en_q;
        thresh_d = thresh_q;
        lane_s   = 2'd0;
        case (state_q)
            IDLE: begin
                if (Write != 4'b0000) begin
                    if (Address == 2'd0) begin
                        lane_s  = top_lane(Write);
                        wr_d    = 1'b1;
                        wbyte_d = lane_byte(DataIn, lane_s);
                        data_d  = DataIn;
                        be_d    = clear_lane(Write, lane_s);
                        state_d = PUSH;
                    end else begin
                        if (Address == 2'd2) begin
                            irq_en_d      = Write[0] ? DataIn[0]     : irq_en_q;
                            thresh_d[7:0] = Write[1] ? DataIn[15:8]  : thresh_q[7:0];
                            thresh_d[8]   = Write[2] ? DataIn[16]    : thresh_q[8];
                        end else begin
                            irq_en_d = irq_en_q;
                        end
                        state_d = ACK;
                    end
                end else if (Read) begin
                    case (Address)
                        2'd0: begin
                            if (uart_data_ready) begin
                                dout_d = {23'd0, 1'b1, uart_data_out};
                                rd_d   = 1'b1;
                            end else begin
                                dout_d = 32'd0;
                            end
                        end
                        2'd1:    dout_d = {21'd0, irq_q, rx_cnt_s, uart_data_ready};
                        2'd2:    dout_d = {15'd0, thresh_q, 7'd0, irq_en_q};
                        default: dout_d = 32'd0;
                    endcase
                    state_d = ACK;
                end else begin
                    state_d = IDLE;
                end
            end
            PUSH: begin
                if (be_q != 4'b0000) begin
                    lane_s  = top_lane(be_q);
                    wr_d    = 1'b1;
                    wbyte_d = lane_byte(data_q, lane_s);
                    be_d    = clear_lane(be_q, lane_s);
                end else begin
                    state_d = ACK;
                end
            end
            ACK: state_d = WAIT_DROP;
            WAIT_DROP: begin
                if (!Read && (Write == 4'b0000)) begin
                    state_d = IDLE;
                end else begin
                    state_d = WAIT_DROP;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign ack_d = (state_d == ACK);
    assign irq_d = irq_en_q & (thresh_q != 9'd0) & (rx_cnt_s >= thresh_q);

    // State and output registers; reset drops any in-flight push sequence.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            data_q   <= 32'd0;
            be_q     <= 4'd0;
            dout_q   <= 32'd0;
            ack_q    <= 1'b0;
            irq_q    <= 1'b0;
            wr_q     <= 1'b0;
            wbyte_q  <= 8'd0;
            rd_q     <= 1'b0;
            irq_en_q <= 1'b0;
            thresh_q <= THRESH_RESET;
        end else begin
            state_q  <= state_d;
            data_q   <= data_d;
            be_q     <= be_d;
            dout_q   <= dout_d;
            ack_q    <= ack_d;
            irq_q    <= irq_d;
            wr_q     <= wr_d;
            wbyte_q  <= wbyte_d;
            rd_q     <= rd_d;
            irq_en_q <= irq_en_d;
            thresh_q <= thresh_d;
        end
    end

    assign DataOut      = dout_q;
    assign Ack          = ack_q;
    assign irq          = irq_q;
    assign uart_write   = wr_q;
    assign uart_data_in = wbyte_q;
    assign uart_read    = rd_q;

endmodule

// File: doc/uart_bus_bridge.md
Name: uart_bus_bridge

Overview:
Memory-mapped slave that connects the MIPS32 core's data-memory bus to the minimal UART (uart_min), sitting directly upstream of its TX FIFO write port and downstream of its RX FIFO read port.
Decodes a 4-word register window (DATA, STATUS, CONTROL, reserved) and runs the bus request/acknowledge handshake.
Serialises byte-enabled word writes into successive single-byte TX FIFO pushes.
Raises a level interrupt when the RX FIFO occupancy reaches a programmable threshold.

Parameters:
THRESH_RESET, 9'd1, reset value of the RX interrupt threshold
COUNT_WIDTH, 9, width of uart_rx_count (must match the UART FIFO count width)

Ports:
clock  input  1  system clock; all logic is on the rising edge
reset  input  1  synchronous, active-high reset
Address  input  2  word index within the UART window
DataIn  input  32  bus write data
Write  input  4  byte-enable write strobes (bit3 = DataIn[31:24]); held until Ack
Read  input  1  read request; held until Ack
DataOut  output  32  read data, registered
Ack  output  1  one-cycle transfer acknowledge
irq  output  1  RX threshold interrupt, level, registered
uart_write  output  1  TX FIFO enqueue pulse
uart_data_in  output  8  TX byte, valid while uart_write=1
uart_read  output  1  RX FIFO dequeue pulse
uart_data_out  input  8  RX FIFO head (first-word-fall-through)
uart_data_ready  input  1  RX FIFO non-empty
uart_rx_count  input  COUNT_WIDTH  RX FIFO occupancy

Behaviour:
- Clock and reset: one clock (clock); reset is synchronous and active-high.
- Reset values: DataOut=0, Ack=0, irq=0, uart_write=0, uart_read=0, uart_data_in=0, irq_en=0, threshold=THRESH_RESET, state=IDLE.
- Reset mid-operation: aborts any push sequence and returns to IDLE. Bytes not yet pushed are dropped, and no Ack is issued for the aborted request.
- FSM states: IDLE, PUSH, ACK, WAIT_DROP.
- IDLE: a request is Write!=0 or Read=1. Write has priority when both are asserted; the read is then ignored (no pop). The request is captured on the cycle it is seen (Address, DataIn, byte enables).
  - DATA write: go to PUSH.
  - Any other request: perform the action and go to ACK.
- PUSH (DATA write): one uart_write pulse per enabled byte, on consecutive cycles, in order byte3, byte2, byte1, byte0; disabled bytes are skipped with no gap.
  - The first push occurs the cycle after capture.
  - Ack is asserted the cycle after the last push.
  - N enabled bytes give Ack at capture+N+1.
- ACK: Ack=1 for exactly one cycle, then WAIT_DROP.
- Read response: DataOut and uart_read are registered on the capture cycle, so they appear together with Ack at capture+1.
- WAIT_DROP: stays until Read=0 and Write=0, then IDLE. A held request is never executed twice.
- Register map (Address):
  - 0 DATA, read:
    - uart_data_ready=1: DataOut={23'b0,1'b1,uart_data_out}, with a one-cycle uart_read pulse.
    - uart_data_ready=0: DataOut=32'h0, no pop.
  - 0 DATA, write: TX pushes as above. There is no TX full check; the software owns flow control.
  - 1 STATUS, read: DataOut={21'b0, irq, uart_rx_count[8:0], uart_data_ready}. Writes are acked and ignored.
  - 2 CONTROL:
    - bit0 = irq_en, bits[16:8] = threshold.
    - Write[0] updates irq_en from DataIn[0].
    - Write[1] updates threshold[7:0] from DataIn[15:8].
    - Write[2] updates threshold[8] from DataIn[16].
    - Write[3] is ignored.
    - Reads return the register.
  - 3 reserved: reads return 0; writes are acked with no effect.
- DataOut holds its last read value across writes and idle cycles.
- irq is registered each cycle: irq <= irq_en & (threshold!=0) & (uart_rx_count >= threshold), compared unsigned at 9 bits. It deasserts the cycle after the condition falls. Threshold 0 disables irq.

Test Plan:
- Reset, then read STATUS with RX empty -> DataOut=0, Ack one cycle at capture+1; irq=0 and uart_write=0 throughout.
- Write DATA with DataIn=32'h41424344, Write=4'b1111 -> uart_write high for 4 consecutive cycles carrying 8'h41, 42, 43, 44; Ack at capture+5; nothing further while Write is held.
- Write DATA with Write=4'b0101 and DataIn=32'h00AA00BB -> exactly 2 pushes, 8'hAA then 8'hBB; Ack at capture+3.
- Feed RX data 8'h5A (uart_data_ready=1) and read DATA -> DataOut=32'h0000015A with a single uart_read pulse. Read again with the FIFO empty -> DataOut=0, no uart_read.
- Write CONTROL 32'h00000301 with Write=4'b0011, then ramp uart_rx_count 0->3 -> irq rises the cycle after count=3; threshold=0 -> irq never asserts.
- Assert reset during the second byte of a 4-byte push -> no further uart_write, no Ack. The next request after reset completes normally; simultaneous Read+Write to DATA -> bytes pushed, no uart_read.
